// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO with registered send/tx_data_ready output stage
// Define UART_TX_FIFO_STATS_EN to add the drop_cnt and tx_cnt statistics outputs.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_en,
  input  logic                          flush,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+2)-1:0]    level,
  output logic                          overflow,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          send,
  input  logic                          tx_data_ready
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   tx_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(DEPTH + 2);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;

  logic wr_accept;
  logic drop;
  logic transfer;
  logic load;

  assign full  = (cnt == CW'(DEPTH));
  assign level = LW'(cnt) + LW'(send);
  assign empty = (level == '0);

  // Drop decision uses the registered full flag, so a same-cycle pop never rescues a write.
  always_comb begin
    transfer  = send && tx_data_ready;
    wr_accept = wr_en && !full && !flush;
    drop      = wr_en && full && !flush;
    load      = (!send || transfer) && (cnt != '0) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      send     <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        tx_data <= mem[rd_ptr];
        send    <= 1'b1;
        rd_ptr  <= rd_ptr + 1'b1;
      end else if (transfer) begin
        send <= 1'b0;
      end
      if (wr_accept && !load) begin
        cnt <= cnt + 1'b1;
      end else if (!wr_accept && load) begin
        cnt <= cnt - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  // tx_cnt survives flush: a byte handed over in the flush cycle was still delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      if (transfer) begin
        tx_cnt <= tx_cnt + 16'd1;
      end
      if (flush) begin
        drop_cnt <= '0;
      end else if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized and directed checks of uart_tx_fifo against a queue model
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          flush;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic [DW-1:0] tx_data;
  logic          send;
  logic          tx_data_ready;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]   drop_cnt;
  logic [15:0]   tx_cnt;
`endif

  uart_tx_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .flush         (flush),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .tx_data       (tx_data),
    .send          (send),
    .tx_data_ready (tx_data_ready)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .drop_cnt      (drop_cnt),
    .tx_cnt        (tx_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: stored bytes in a queue plus the presented byte.
  logic [DW-1:0] mq[$];
  logic          m_send = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf  = 1'b0;
  int            m_drop = 0;
  int            m_tx   = 0;
  bit            m_xfer;
  bit            m_ld;
  bit            m_was_full;
  logic [DW-1:0] dut_out[$];
  bit            check_en = 1'b0;

  always @(posedge clk) begin
    if (!rst && send === 1'b1 && tx_data_ready === 1'b1) dut_out.push_back(tx_data);
    if (rst) begin
      mq.delete();
      m_send = 1'b0;
      m_data = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_tx   = 0;
    end else begin
      m_xfer = m_send && tx_data_ready;
      if (m_xfer) m_tx = (m_tx + 1) % 65536;
      if (flush) begin
        mq.delete();
        m_send = 1'b0;
        m_data = '0;
        m_ovf  = 1'b0;
        m_drop = 0;
      end else begin
        m_was_full = (mq.size() == DEPTH);
        m_ld = (!m_send || m_xfer) && (mq.size() != 0);
        if (m_ld) begin
          m_data = mq.pop_front();
          m_send = 1'b1;
        end else if (m_xfer) begin
          m_send = 1'b0;
        end
        if (wr_en) begin
          if (m_was_full) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end else begin
            mq.push_back(wr_data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("send", 32'(send), 32'(m_send));
      chk("level", 32'(level), 32'(mq.size()) + 32'(m_send));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0 && !m_send));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_send) chk("tx_data", 32'(tx_data), 32'(m_data));
`ifdef UART_TX_FIFO_STATS_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("tx_cnt", 32'(tx_cnt), 32'(m_tx));
`endif
    end
  end

  task automatic step(input bit we, input logic [DW-1:0] d, input bit rdy, input bit fl);
    wr_en         = we;
    wr_data       = d;
    tx_data_ready = rdy;
    flush         = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mx;
    rst = 1'b1; wr_en = 0; wr_data = 0; flush = 0; tx_data_ready = 0;
    @(negedge clk);
    do_reset();
    check_en = 1'b1;
    chk("rst_send", 32'(send), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // 1: latency of two edges into an empty FIFO
    dut_out.delete();
    step(1, 8'hA5, 1, 0);
    chk("t1_level_n", 32'(level), 1);
    chk("t1_send_n", 32'(send), 0);
    step(0, 8'h00, 1, 0);
    chk("t1_level_n1", 32'(level), 1);
    chk("t1_send_n1", 32'(send), 1);
    chk("t1_data_n1", 32'(tx_data), 32'hA5);
    step(0, 8'h00, 1, 0);
    chk("t1_level_n2", 32'(level), 0);
    chk("t1_send_n2", 32'(send), 0);
    chk("t1_out_cnt", 32'(dut_out.size()), 1);

    // 2: fill to DEPTH+1, drop one, drain in order
    dut_out.delete();
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0);
    chk("t2_full", 32'(full), 1);
    chk("t2_level17", 32'(level), 17);
    step(1, 8'hFF, 0, 0);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_level_keep", 32'(level), 17);
    for (int i = 0; i < 40 && empty !== 1'b1; i++) step(0, 8'h00, 1, 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_out_cnt", 32'(dut_out.size()), 17);
    for (int i = 0; i < 17 && i < dut_out.size(); i++) chk("t2_order", 32'(dut_out[i]), 32'(i));

    // 3: hold stability under backpressure
    dut_out.delete();
    step(1, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 0);
      chk("t3_hold_send", 32'(send), 1);
      chk("t3_hold_data", 32'(tx_data), 32'h3C);
    end
    step(0, 8'h00, 1, 0);
    chk("t3_send_drop", 32'(send), 0);
    step(0, 8'h00, 0, 0);
    chk("t3_one_xfer", 32'(dut_out.size()), 1);
    if (dut_out.size() > 0) chk("t3_byte", 32'(dut_out[0]), 32'h3C);

    // 4: streaming across pointer wrap
    dut_out.delete();
    mx = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(i), 1, 0);
      if (int'(level) > mx) mx = int'(level);
    end
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("t4_max_level", 32'(mx <= 2), 1);
    chk("t4_out_cnt", 32'(dut_out.size()), 40);
    for (int i = 0; i < 40 && i < dut_out.size(); i++) chk("t4_order", 32'(dut_out[i]), 32'(i));

    // 5: flush beats a simultaneous write
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0);
    chk("t5_level5", 32'(level), 5);
    chk("t5_ovf_before", 32'(overflow), 1);
    dut_out.delete();
    step(1, 8'h77, 0, 1);
    chk("t5_level", 32'(level), 0);
    chk("t5_send", 32'(send), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_tx_data", 32'(tx_data), 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    chk("t5_no_byte", 32'(dut_out.size()), 0);

`ifdef UART_TX_FIFO_STATS_EN
    // 6: statistics counters
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("t6_drop_cnt", 32'(drop_cnt), 3);
    chk("t6_tx_cnt", 32'(tx_cnt), 4);
    step(0, 8'h00, 0, 1);
    chk("t6_drop_flush", 32'(drop_cnt), 0);
    chk("t6_tx_flush", 32'(tx_cnt), 4);
`endif

    // Randomized traffic with occasional flush and reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 40 && empty !== 1'b1; i++) step(0, 8'h00, 1, 0);
    chk("final_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the internal host at full clock rate and stores them in a circular FIFO. It presents the bytes one at a time on the transmitter's tx_data / send / tx_data_ready handshake. This decouples bursty software writes from the slow serial bit rate.

Parameters:
DATA_W, 8, byte width; matches the UART data type width.
DEPTH, 16, storage entries; power of 2, minimum 2. Total capacity is DEPTH+1, counting the output register.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
wr_data  input  DATA_W  byte to enqueue
wr_en  input  1  enqueue strobe, one byte per cycle
flush  input  1  synchronous clear of all contents
full  output  1  storage array holds DEPTH entries
empty  output  1  storage array and output register both empty
level  output  $clog2(DEPTH+2)  entries held, storage plus output register
overflow  output  1  sticky: a write was dropped
tx_data  output  DATA_W  byte presented to the transmitter
send  output  1  tx_data valid
tx_data_ready  input  1  transmitter accepts tx_data

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset and flush both clear state. Resulting values: send=0, tx_data=0, full=0, empty=1, level=0, overflow=0, pointers=0.
- Storage:
  - DEPTH-entry array; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally.
  - cnt is $clog2(DEPTH)+1 bits.
  - full = (cnt==DEPTH), computed from registered state.
- Write:
  - Accepted when wr_en && !full && !flush; writes mem[wr_ptr] and increments wr_ptr.
  - wr_en && full drops the byte and sets overflow. This holds even if a pop frees a slot in the same cycle.
- Output stage:
  - send and tx_data are registers.
  - A transfer occurs on any cycle with send && tx_data_ready.
  - Load condition: (!send || transfer) && cnt!=0. On load, tx_data<=mem[rd_ptr], send<=1, rd_ptr increments.
  - If a transfer occurs and cnt==0, send<=0.
  - There is no bypass. Latency is 2 cycles: a wr_en at edge N into an empty FIFO gives send=1 after edge N+1.
- Hold rule: while send=1 && tx_data_ready=0, tx_data and send stay stable.
- Back-to-back: when tx_data_ready is held high, one byte is presented per cycle until the FIFO empties.
- Simultaneous write and load: cnt is unchanged; level is adjusted by each event independently.
- level = cnt + send. empty = (level==0).
- Flush:
  - Flush has priority over wr_en. A write in a flush cycle is dropped and does not set overflow.
  - A transfer coinciding with flush counts as delivered; the downstream transmitter has already sampled it.
- Reset mid-transfer: the byte in the output register is discarded, and send drops after that edge.
- FIFO order is preserved across pointer wrap.

Optional Feature:
UART_TX_FIFO_STATS_EN:
- Defined: adds output drop_cnt[15:0]. It increments on every dropped write, saturates at 0xFFFF, and is cleared by rst or flush.
- Also adds output tx_cnt[15:0], which increments on every transfer and wraps. It is cleared by rst only.
- Undefined: neither port nor counter exists. Core behaviour is identical in both builds.

Test Plan:
1. Reset, then tx_data_ready=1 and write 0xA5 at edge N. Expect send=1, tx_data=0xA5 after N+1; send=0 after N+2; level sequence 1,1,0.
2. tx_data_ready=0 and write 0x00..0x10 (17 bytes, DEPTH=16). Expect full=1 and level=17. Then write 0xFF: overflow=1, level stays 17. Then set ready=1: output is 0x00..0x10 in order, never 0xFF, and empty=1 at the end.
3. Write 0x3C and hold tx_data_ready=0 for 5 cycles. Expect send=1 and tx_data=0x3C stable throughout. Raise ready for 1 cycle: exactly one transfer, then send=0.
4. ready=1 and wr_en every cycle, streaming 40 incrementing bytes. Expect output 0..39 in order with one per cycle after a 2-cycle fill, level ≤2, and correct pointer wrap.
5. Fill to level=5 with ready=0 and overflow set, then pulse flush together with wr_en=1. Next cycle: level=0, send=0, overflow=0, and the written byte is absent.
6. With STATS_EN defined: perform 3 dropped writes and 4 transfers. Expect drop_cnt=3 and tx_cnt=4. After flush: drop_cnt=0, tx_cnt=4.
